// File: rtl/execute_pipe_unit.sv
// Execute stage: single-cycle ALU behind a valid/ready output register, with an
// optional iterative shift-add multiplier compiled in when EXEC_MUL_EN is defined.
module execute_pipe_unit #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_ctr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [SH_W-1:0]   shamt,
  input  logic              branch_in,
  input  logic              jump_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              v,
  output logic              c_out,
  output logic              illegal,
  output logic              branch_reg,
  output logic              jump_reg,
  output logic              taken
);
  localparam int LUI_SH = (DATA_W >= 16) ? DATA_W - 16 : 0;
  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_NOR = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8,  OP_SRL = 5'd9,  OP_SRA = 5'd10, OP_LUI = 5'd11;

`ifdef EXEC_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd12;
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);
  typedef enum logic [1:0] {S_IDLE, S_FULL, S_MUL} state_t;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              is_mul;
  assign is_mul = (alu_ctr == OP_MUL);
`else
  typedef enum logic [1:0] {S_IDLE, S_FULL} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d, v_q, v_d, c_q, c_d, ill_q, ill_d;
  logic              branch_q, branch_d, jump_q, jump_d;
  logic [DATA_W:0]   add_full, sub_full;
  logic [DATA_W-1:0] alu_res;
  logic              alu_v, alu_c, alu_ill, accept;

  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  // a + ~b + 1: the carry out is the inverted borrow
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (alu_ctr)
      OP_ADD: begin
        alu_res = add_full[DATA_W-1:0];
        alu_c   = add_full[DATA_W];
        alu_v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (add_full[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[DATA_W-1:0];
        alu_c   = sub_full[DATA_W];
        alu_v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (sub_full[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_LUI:  alu_res = op_b << LUI_SH;
`ifdef EXEC_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  assign in_ready = !RST && ((state_q == S_IDLE) || ((state_q == S_FULL) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    v_d      = v_q;
    c_d      = c_q;
    ill_d    = ill_q;
    branch_d = branch_q;
    jump_d   = jump_q;
`ifdef EXEC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
      branch_d = branch_in;
      jump_d   = jump_in;
`ifdef EXEC_MUL_EN
      if (is_mul) begin
        state_d  = S_MUL;
        mcand_d  = op_a;
        mplier_d = op_b;
        acc_d    = '0;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = S_FULL;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        v_d      = alu_v;
        c_d      = alu_c;
        ill_d    = alu_ill;
      end
    end else if ((state_q == S_FULL) && out_ready) begin
      state_d = S_IDLE;
    end
`ifdef EXEC_MUL_EN
    else if (state_q == S_MUL) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SH_W'(1);
      if (cnt_q == CNT_LAST) begin
        state_d  = S_FULL;
        result_d = acc_d;
        zero_d   = (acc_d == '0);
        v_d      = 1'b0;
        c_d      = 1'b0;
        ill_d    = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      ill_q    <= 1'b0;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      v_q      <= v_d;
      c_q      <= c_d;
      ill_q    <= ill_d;
      branch_q <= branch_d;
      jump_q   <= jump_d;
`ifdef EXEC_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign result     = result_q;
  assign zero       = zero_q;
  assign v          = v_q;
  assign c_out      = c_q;
  assign illegal    = ill_q;
  assign branch_reg = branch_q;
  assign jump_reg   = jump_q;
  assign taken      = jump_q | (branch_q & zero_q);
endmodule

// File: tb/tb_execute_pipe_unit.sv
// Directed bench for execute_pipe_unit (DATA_W=32): scoreboard of expected results
// pushed on accept and compared on each output handshake.
module tb_execute_pipe_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  alu_ctr;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  shamt;
  logic        branch_in, jump_in;
  logic        zero, v, c_out, illegal, branch_reg, jump_reg, taken;

  typedef struct packed {
    logic [31:0] res;
    logic z, v, c, ill, br, jp, tk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  execute_pipe_unit #(.DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .branch_in(branch_in), .jump_in(jump_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .v(v), .c_out(c_out),
    .illegal(illegal), .branch_reg(branch_reg), .jump_reg(jump_reg), .taken(taken)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic br, input logic jp);
    exp_t e;
    longint unsigned ua, ub;
    longint sa, sb, s;
    e  = '0;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'd0: begin
        s = sa + sb; e.res = a + b;
        e.c = (ua + ub) > 64'hFFFF_FFFF; e.v = (s > SMAX) || (s < SMIN);
      end
      5'd1: begin
        s = sa - sb; e.res = a - b;
        e.c = (ua >= ub); e.v = (s > SMAX) || (s < SMIN);
      end
      5'd2:  e.res = a & b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a ^ b;
      5'd5:  e.res = ~(a | b);
      5'd6:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      5'd7:  e.res = (ua < ub) ? 32'd1 : 32'd0;
      5'd8:  e.res = a << sh;
      5'd9:  e.res = a >> sh;
      5'd10: e.res = $signed(a) >>> sh;
      5'd11: e.res = {b[15:0], 16'h0000};
      5'd12: begin
`ifdef EXEC_MUL_EN
        e.res = 32'(ua * ub);
`else
        e.ill = 1'b1;
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.z  = (e.res == 32'd0);
    e.br = br;
    e.jp = jp;
    e.tk = jp | (br & e.z);
    return e;
  endfunction

  task automatic set_in(input logic iv, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic br, input logic jp, input logic ordy);
    in_valid = iv; alu_ctr = op; op_a = a; op_b = b; shamt = sh;
    branch_in = br; jump_in = jp; out_ready = ordy;
  endtask

  // Handshake bookkeeping for the current cycle, then advance to just after the next edge.
  task automatic tick();
    exp_t e;
    if (RST) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_empty: observed unexpected output %0h expected none", result);
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("result", {32'b0, result}, {32'b0, e.res});
          check("flags zvci", {60'b0, zero, v, c_out, illegal}, {60'b0, e.z, e.v, e.c, e.ill});
          check("ctrl br/jp/taken", {61'b0, branch_reg, jump_reg, taken}, {61'b0, e.br, e.jp, e.tk});
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(alu_ctr, op_a, op_b, shamt, branch_in, jump_in));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic br, input logic jp, input logic ordy);
    set_in(iv, op, a, b, sh, br, jp, ordy);
    #1;
    tick();
  endtask

  // Count busy cycles until out_valid, bounded.
  task automatic wait_out(input int exp_busy, input string tag);
    int n;
    n = 0;
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    while (!out_valid && n < 100) begin
      checks++;
      assert (in_ready === 1'b0) else begin
        errors++;
        $error("FAIL %s in_ready_busy: observed %b expected 0", tag, in_ready);
      end
      tick();
      #1;
      n++;
    end
    check(tag, 64'(n), 64'(exp_busy));
  endtask

  logic [38:0] snap;
  logic [4:0]  ops [14];
  int          nv;

  initial begin
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd31};
    RST = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst in_ready", {63'b0, in_ready}, 64'd0);
    check("rst outputs", {24'b0, out_valid, result, zero, v, c_out, illegal, branch_reg, jump_reg, taken}, 64'd0);
    RST = 1'b0;
    #1;
    check("in_ready after rst", {63'b0, in_ready}, 64'd1);

    // ADD overflow into the sign bit
    drive(1'b1, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b1);
    check("add latency out_valid", {63'b0, out_valid}, 64'd1);
    check("add result", {32'b0, result}, 64'h8000_0000);
    check("add v/c/zero", {61'b0, v, c_out, zero}, 64'b100);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("idle after drain", {63'b0, out_valid}, 64'd0);

    // SUB to zero with branch, then back-pressure for three cycles
    drive(1'b1, 5'd1, 32'd5, 32'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    check("sub zero/taken", {62'b0, zero, taken}, 64'b11);
    snap = {result, zero, v, c_out, illegal, branch_reg, jump_reg, taken};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd0, 32'd1, 32'd1, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      check("hold in_ready", {63'b0, in_ready}, 64'd0);
      check("hold outputs", {25'b0, result, zero, v, c_out, illegal, branch_reg, jump_reg, taken}, {25'b0, snap});
      tick();
    end
    check("hold out_valid", {63'b0, out_valid}, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Back-to-back ADD, OR, SLL without bubbles
    drive(1'b1, 5'd0, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, 1'b1);
    check("b2b 1 out_valid", {63'b0, out_valid}, 64'd1);
    drive(1'b1, 5'd3, 32'hF0, 32'h0F, 5'd0, 1'b0, 1'b0, 1'b1);
    check("b2b 2 out_valid", {63'b0, out_valid}, 64'd1);
    drive(1'b1, 5'd8, 32'd1, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    check("b2b 3 out_valid", {63'b0, out_valid}, 64'd1);
    check("sll result", {32'b0, result}, 64'h10);

    // Every opcode class with random operands, streamed
    foreach (ops[i])
      drive(1'b1, ops[i], $urandom(), (i % 3 == 0) ? 32'h8000_0000 : $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    drive(1'b1, 5'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 5'd10, 32'h8000_0010, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 5'd13, 32'd9, 32'd9, 5'd0, 1'b1, 1'b0, 1'b1);
    check("illegal result/flag", {31'b0, result, illegal}, 64'd1);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // MUL 7*6
    drive(1'b1, 5'd12, 32'd7, 32'd6, 5'd0, 1'b0, 1'b0, 1'b1);
`ifdef EXEC_MUL_EN
    wait_out(32, "mul busy cycles");
    check("mul result", {32'b0, result}, 64'd42);
`else
    wait_out(0, "mul busy cycles");
    check("mul illegal", {31'b0, result, illegal}, 64'd1);
`endif
    tick();
    drive(1'b1, 5'd12, 32'hDEAD_BEEF, 32'h0123_4567, 5'd0, 1'b0, 1'b1, 1'b1);
`ifdef EXEC_MUL_EN
    wait_out(32, "mul2 busy cycles");
`else
    wait_out(0, "mul2 busy cycles");
`endif
    tick();

    // Reset in the middle of a multiply
    drive(1'b1, 5'd12, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (9) drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    RST = 1'b1;
    set_in(1'b1, 5'd0, 32'd1, 32'd1, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    check("in_ready during rst", {63'b0, in_ready}, 64'd0);
    tick();
    check("post rst outputs", {24'b0, out_valid, result, zero, v, c_out, illegal, branch_reg, jump_reg, taken}, 64'd0);
    RST = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("in_ready after mul rst", {63'b0, in_ready}, 64'd1);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) nv++;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    end
    check("aborted mul no out_valid", 64'(nv), 64'd0);
    drive(1'b1, 5'd0, 32'd2, 32'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    check("add after rst", {32'b0, result}, 64'd5);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Reset wins over a simultaneous consume and offer
    drive(1'b1, 5'd0, 32'd1, 32'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    RST = 1'b1;
    set_in(1'b1, 5'd3, 32'hFF, 32'h1, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    tick();
    RST = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("rst priority outputs", {24'b0, out_valid, result, zero, v, c_out, illegal, branch_reg, jump_reg, taken}, 64'd0);

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_pipe_unit.md
EXECUTE_PIPE_UNIT -- requirements
Module: execute_pipe_unit

Interface
REQ-001 Parameter DATA_W, default 32, shall set the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SH_W, default $clog2(DATA_W), shall set the shift-amount width.
REQ-003 CLK  in  1  shall be the single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  shall be a synchronous, active-high reset.
REQ-005 in_valid  in  1  shall flag that an operation is offered.
REQ-006 in_ready  out  1  shall flag that the unit accepts an operation this cycle.
REQ-007 alu_ctr  in  5  shall carry the operation code.
REQ-008 op_a, op_b  in  DATA_W  shall carry the operands (busA, and busB or the extended immediate).
REQ-009 shamt  in  SH_W  shall carry the shift amount.
REQ-010 branch_in, jump_in  in  1  shall carry the control flags travelling with the operation.
REQ-011 out_valid  out  1  shall flag that a result is held.
REQ-012 out_ready  in  1  shall flag that the consumer takes the result.
REQ-013 result  out  DATA_W  shall carry the operation result.
REQ-014 zero, v, c_out, illegal  out  1  shall carry the result flags.
REQ-015 branch_reg, jump_reg, taken  out  1  shall carry the registered control flags for fetch.

Function
REQ-016 Opcodes shall be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (op_b<<(DATA_W-16)), 12 MUL (low DATA_W bits); all other codes are illegal.
REQ-017 An operation shall be accepted on a cycle where in_valid && in_ready.
REQ-018 The FSM shall have three states: IDLE (output register empty), FULL (result held), MUL (multiply in progress).
REQ-019 in_ready shall be 1 in IDLE, 1 in FULL only when out_ready is 1, and 0 in MUL.
REQ-020 A single-cycle operation accepted in cycle N shall present out_valid=1 and its result in cycle N+1 (latency 1), with state FULL.
REQ-021 MUL shall use an iterative shift-add over exactly DATA_W cycles in state MUL, with out_valid=1 on the cycle after the last iteration (latency DATA_W+1).
REQ-022 Whenever out_valid && !out_ready, result, the flags and the control outputs shall hold stable.
REQ-023 When out_valid && out_ready and a new operation is accepted in the same cycle, the new result shall replace the old one in the next cycle with no bubble.
REQ-024 When out_valid && out_ready and nothing is accepted, the unit shall return to IDLE with out_valid=0.
REQ-025 zero shall be (result==0); v shall be signed overflow for ADD/SUB and 0 for all other operations; c_out shall be the carry (ADD) or the inverted borrow (SUB) out of bit DATA_W-1, and 0 for all other operations.
REQ-026 An illegal opcode shall complete with latency 1, result=0, illegal=1, and v=c_out=0.
REQ-027 branch_reg and jump_reg shall be the captured branch_in and jump_in; taken shall be jump_reg | (branch_reg & zero).
REQ-028 Shifts shall use only the SH_W-bit shamt, so shift amounts wrap modulo DATA_W.
REQ-029 Arithmetic shall wrap modulo 2^DATA_W.

Reset
REQ-030 On RST=1 the state shall go to IDLE and out_valid, result, zero, v, c_out, illegal, branch_reg, jump_reg and taken shall all be 0.
REQ-031 RST asserted during MUL shall abort the multiply and discard it, with no out_valid afterwards.
REQ-032 RST shall take priority over any simultaneous handshake.
REQ-033 in_ready shall be 0 while RST=1 and shall be 1 on the first cycle after RST is released.

Configuration
REQ-034 Macro EXEC_MUL_EN defined: opcode 12 shall execute MUL as specified in REQ-021.
REQ-035 Macro EXEC_MUL_EN undefined: the multiplier and the MUL state shall be absent, and opcode 12 shall be treated as illegal per REQ-026.

Verification
REQ-036 Reset then ADD 0x7FFFFFFF+1 (DATA_W=32) -> next cycle: result=0x80000000, v=1, c_out=0, zero=0, out_valid=1.
REQ-037 SUB 5-5 with branch_in=1 -> zero=1, taken=1; hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0.
REQ-038 Back-to-back ADD, OR, SLL (shamt=4, op_a=1) with out_ready=1 -> results on three consecutive cycles, last result=0x10.
REQ-039 MUL 7*6 with EXEC_MUL_EN defined -> in_ready=0 for 32 cycles, then result=42; with EXEC_MUL_EN undefined -> next cycle result=0, illegal=1.
REQ-040 Start MUL, assert RST at iteration 10 -> out_valid stays 0, in_ready=1 on the first cycle after reset, next ADD 2+3=5 correct.
